// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: address and control sequencer for the single-MAC 32-point transform.
// Walks bin k (outer) and sample n (inner), one (k,n) issue per cycle, producing sample and
// coefficient read addresses, the MAC sload strobe, and a flag marking the cycle in which the
// MAC's registered sum holds a finished bin.
module mac_seq_ctrl #(
    parameter int unsigned N        = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_BINS = 32
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] smp_addr,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              mac_sload,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_bin
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] DRAIN1 = 2'd2;
    localparam logic [1:0] DRAIN2 = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_BINS - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] k_q, k_d;
    // Running k*n mod N; the natural ADDR_W-bit wrap supplies the modulo.
    logic [ADDR_W-1:0] acc_q, acc_d;

    // Completion delay line: stage 1 lines up with the last term's data cycle,
    // stage 2 with the cycle the MAC register holds the finished sum.
    logic              s1_v_q, s2_v_q;
    logic [ADDR_W-1:0] s1_k_q, s2_k_q;

    logic issue;
    logic last_term;
    logic last_pair;

    assign issue     = (state_q == RUN);
    assign last_term = issue && (n_q == LAST_N);
    assign last_pair = last_term && (k_q == LAST_K);

    // Next-state and counter/accumulator update.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    n_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                if (last_pair) begin
                    // Counters return to zero so the address outputs idle at 0.
                    state_d = DRAIN1;
                    n_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end else if (last_term) begin
                    n_d   = '0;
                    k_d   = k_q + ONE;
                    acc_d = '0;
                end else begin
                    n_d   = n_q + ONE;
                    acc_d = acc_q + k_q;
                end
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: state_d = IDLE;
            default: begin
                state_d = IDLE;
                n_d     = '0;
                k_d     = '0;
                acc_d   = '0;
            end
        endcase
    end

    // Control state, counters and coefficient accumulator.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // Two-stage {last_term, k} delay covering memory latency plus the MAC register.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            s1_v_q <= 1'b0;
            s1_k_q <= '0;
            s2_v_q <= 1'b0;
            s2_k_q <= '0;
        end else begin
            s1_v_q <= last_term;
            s1_k_q <= last_term ? k_q : '0;
            s2_v_q <= s1_v_q;
            s2_k_q <= s1_k_q;
        end
    end

    assign busy      = (state_q != IDLE);
    assign rd_en     = issue;
    assign smp_addr  = n_q;
    assign coef_addr = acc_q;
    assign mac_sload = issue && (n_q == '0);
    assign out_valid = s2_v_q;
    assign out_bin   = s2_k_q;
    assign done      = s2_v_q && (s2_k_q == LAST_K);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: two instances (32 bins and 1 bin) share start/aclr. A run-offset
// model derives every output from the issue schedule; memory and MAC models check the sums.
module tb_mac_seq_ctrl;

    localparam int N = 32;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic       sload;
        logic       ov;
        logic [4:0] smp;
        logic [4:0] coef;
        logic [4:0] bin;
    } exp_t;

    logic       clk = 1'b0;
    logic       aclr = 1'b0;
    logic       start = 1'b0;
    logic [1:0] busy, done, rd_en, sload, ov;
    logic [4:0] smp [2];
    logic [4:0] coef[2];
    logic [4:0] bin [2];

    logic [15:0] smem[N];
    logic [15:0] cmem[N];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: whether a run is active and which run-relative cycle this is.
    bit act[2] = '{1'b0, 1'b0};
    int rel[2] = '{0, 0};

    // MAC model: 1-cycle memories feeding a registered accumulator with registered sload.
    logic [15:0] xq[2], wq[2], accq[2];
    logic        dv[2], slq[2];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.N(32), .ADDR_W(5), .NUM_BINS(32)) u_dut0 (
        .clk(clk), .aclr(aclr), .start(start), .busy(busy[0]), .done(done[0]),
        .rd_en(rd_en[0]), .smp_addr(smp[0]), .coef_addr(coef[0]), .mac_sload(sload[0]),
        .out_valid(ov[0]), .out_bin(bin[0])
    );

    mac_seq_ctrl #(.N(32), .ADDR_W(5), .NUM_BINS(1)) u_dut1 (
        .clk(clk), .aclr(aclr), .start(start), .busy(busy[1]), .done(done[1]),
        .rd_en(rd_en[1]), .smp_addr(smp[1]), .coef_addr(coef[1]), .mac_sload(sload[1]),
        .out_valid(ov[1]), .out_bin(bin[1])
    );

    function automatic int nb_of(input int i);
        return (i == 0) ? 32 : 1;
    endfunction

    function automatic logic [15:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return p[23:8];
    endfunction

    // Dot product of bin k straight from the transform definition.
    function automatic logic [15:0] bin_sum(input int k);
        logic [15:0] s;
        s = '0;
        for (int n = 0; n < N; n++) s = s + prod(smem[n], cmem[(k * n) % N]);
        return s;
    endfunction

    // Outputs implied by the schedule: pair (k,n) issued at run cycle 1+k*N+n,
    // bin k result at (k+1)*N+2, run ends at nb*N+2.
    function automatic exp_t model_out(input int nb, input bit a, input int r);
        exp_t e;
        int   i;
        e = '0;
        if (!a) return e;
        e.busy = (r >= 1) && (r <= nb * N + 2);
        if (r >= 1 && r <= nb * N) begin
            i       = r - 1;
            e.rd_en = 1'b1;
            e.smp   = 5'(i % N);
            e.coef  = 5'(((i / N) * (i % N)) % N);
            e.sload = ((i % N) == 0);
        end
        if (r >= N + 2 && r <= nb * N + 2 && ((r - 2) % N) == 0) begin
            e.ov   = 1'b1;
            e.bin  = 5'((r - 2) / N - 1);
            e.done = (((r - 2) / N) == nb);
        end
        return e;
    endfunction

    task automatic chk(input string name, input int actual, input int required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Run tracker: a run starts on an accepted start and lasts nb*N+2 cycles.
    always @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            act[0] <= 1'b0;
            act[1] <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    if (rel[i] == nb_of(i) * N + 2) act[i] <= 1'b0;
                    rel[i] <= rel[i] + 1;
                end else if (start) begin
                    act[i] <= 1'b1;
                    rel[i] <= 1;
                end
            end
        end
    end

    // Memory and MAC model driven by each DUT's read side.
    always @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            for (int i = 0; i < 2; i++) begin
                xq[i]   <= '0;
                wq[i]   <= '0;
                accq[i] <= '0;
                dv[i]   <= 1'b0;
                slq[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                xq[i]  <= smem[smp[i]];
                wq[i]  <= cmem[coef[i]];
                dv[i]  <= rd_en[i];
                slq[i] <= sload[i];
                if (dv[i]) accq[i] <= (slq[i] ? 16'd0 : accq[i]) + prod(xq[i], wq[i]);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            e = model_out(nb_of(i), act[i], rel[i]);
            chk($sformatf("dut%0d busy", i), int'(busy[i]), int'(e.busy));
            chk($sformatf("dut%0d rd_en", i), int'(rd_en[i]), int'(e.rd_en));
            chk($sformatf("dut%0d mac_sload", i), int'(sload[i]), int'(e.sload));
            chk($sformatf("dut%0d out_valid", i), int'(ov[i]), int'(e.ov));
            chk($sformatf("dut%0d done", i), int'(done[i]), int'(e.done));
            if (e.rd_en) begin
                chk($sformatf("dut%0d smp_addr", i), int'(smp[i]), int'(e.smp));
                chk($sformatf("dut%0d coef_addr", i), int'(coef[i]), int'(e.coef));
            end
            if (e.ov) begin
                chk($sformatf("dut%0d out_bin", i), int'(bin[i]), int'(e.bin));
                chk($sformatf("dut%0d adder_out", i), int'(accq[i]), int'(bin_sum(int'(e.bin))));
            end
        end
    end

    initial begin
        int rst_cnt;
        for (int j = 0; j < N; j++) begin
            smem[j] = 16'd256;
            cmem[j] = 16'd256;
        end

        // Reset held: start toggling must not wake the block.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("reset busy0", int'(busy[0]), 0);
            chk("reset busy1", int'(busy[1]), 0);
            #1 start = ~start;
        end
        @(negedge clk);
        #1 start = 1'b0;
        aclr = 1'b1;
        @(negedge clk);

        // Start held high through the whole first run.
        #1 start = 1'b1;
        @(posedge clk);
        repeat (1) @(negedge clk);
        chk("c1 rd_en", int'(rd_en[0]), 1);
        chk("c1 sload", int'(sload[0]), 1);
        chk("c1 coef", int'(coef[0]), 0);
        repeat (33) @(negedge clk);
        chk("c34 out_valid", int'(ov[0]), 1);
        chk("c34 out_bin", int'(bin[0]), 0);
        chk("c34 adder", int'(accq[0]), 8192);
        chk("c34 nb1 done", int'(done[1]), 1);
        chk("c34 nb1 busy", int'(busy[1]), 1);
        @(negedge clk);
        chk("c35 nb1 busy", int'(busy[1]), 0);
        repeat (31) @(negedge clk);
        chk("c66 out_bin", int'(bin[0]), 1);
        repeat (32) @(negedge clk);
        chk("c98 coef k3n1", int'(coef[0]), 3);
        repeat (10) @(negedge clk);
        chk("c108 smp k3n11", int'(smp[0]), 11);
        chk("c108 coef k3n11", int'(coef[0]), 1);
        repeat (918) @(negedge clk);
        chk("c1026 done", int'(done[0]), 1);
        chk("c1026 out_bin", int'(bin[0]), 31);
        chk("c1026 adder", int'(accq[0]), 8192);
        @(negedge clk);
        chk("c1027 busy", int'(busy[0]), 0);
        @(negedge clk);
        chk("c1028 rd_en", int'(rd_en[0]), 1);
        chk("c1028 sload", int'(sload[0]), 1);
        #1 start = 1'b0;

        // Abort the second run mid-way.
        repeat (499) @(negedge clk);
        #1 aclr = 1'b0;
        #1;
        chk("abort busy", int'(busy[0]), 0);
        chk("abort rd_en", int'(rd_en[0]), 0);
        chk("abort smp", int'(smp[0]), 0);
        chk("abort coef", int'(coef[0]), 0);
        chk("abort out_valid", int'(ov[0]), 0);
        @(negedge clk);
        #1 aclr = 1'b1;
        @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (34) @(negedge clk);
        chk("rerun c34 out_valid", int'(ov[0]), 1);
        chk("rerun c34 out_bin", int'(bin[0]), 0);
        chk("rerun c34 adder", int'(accq[0]), 8192);
        chk("rerun c34 done0", int'(done[0]), 0);
        chk("rerun c34 nb1 done", int'(done[1]), 1);

        // Random phase with random memory contents, start pulses and resets.
        #1 aclr = 1'b0;
        for (int j = 0; j < N; j++) begin
            smem[j] = 16'($urandom);
            cmem[j] = 16'($urandom);
        end
        @(negedge clk);
        #1 aclr = 1'b1;
        rst_cnt = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            #1;
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) aclr = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
                aclr    = 1'b0;
                rst_cnt = int'($urandom_range(1, 3));
            end
            start = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the single MAC datapath in the 32-point transform engine. Per run it walks the bin index k and sample index n, issuing sample-memory and coefficient-ROM read addresses (coefficient index = k·n mod N) and driving the MAC's `sload` so each bin's N-term dot product starts from zero. It flags the cycle in which the MAC's `adder_out` holds a completed bin sum. Bins are processed back-to-back with no idle cycles between them.

## Interface
- `N`, 32: transform length and terms per bin; power of two, ≥ 4.
- `ADDR_W`, 5: log2(N).
- `NUM_BINS`, 32: bins per run, range 1..N.
- `clk`  in  1  single clock; all state updates on rising edge.
- `aclr`  in  1  reset, asynchronous and active-low.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after `done`.
- `done`  out  1  one-cycle pulse, coincident with the last `out_valid`.
- `rd_en`  out  1  read enable to the sample RAM and coefficient ROM; high in issue cycles only.
- `smp_addr`  out  ADDR_W  sample address n.
- `coef_addr`  out  ADDR_W  coefficient address (k·n) mod N.
- `mac_sload`  out  1  to MAC `sload`; high only in n==0 issue cycles.
- `out_valid`  out  1  MAC `adder_out` holds the completed sum for `out_bin` in this cycle.
- `out_bin`  out  ADDR_W  bin index k of the sum flagged by `out_valid`.

## Operation
- States: IDLE, RUN, DRAIN1, DRAIN2.
  - IDLE → RUN when `start`=1.
  - RUN → DRAIN1 after issuing (k=NUM_BINS-1, n=N-1).
  - DRAIN1 → DRAIN2.
  - DRAIN2 → IDLE.
- RUN issues one (k,n) pair per cycle, n fastest.
  - n wraps N-1→0 and increments k.
  - k starts at 0.
- `coef_addr` comes from an ADDR_W-bit accumulator, not a multiplier.
  - Cleared on every n==0 issue.
  - Adds k each subsequent issue; wraps mod N naturally.
- `mac_sload`=1 exactly in n==0 issue cycles.
  - The MAC registers `sload`, so the clear lands in the same cycle the term-0 data returns from the 1-cycle-latency memories.
- Completion flag: a 2-stage delay line of {last_term, k}.
  - last_term = (n==N-1) in an issue cycle.
  - Stage-2 output drives `out_valid`/`out_bin`.
- `done` = `out_valid` AND (`out_bin`==NUM_BINS-1). This occurs in DRAIN2.
- `start` while `busy` is ignored, including in the `done` cycle. A new run may start in the first IDLE cycle.
- Between runs, `adder_out` content is meaningless; consumers qualify it with `out_valid` only.
- `aclr` low at any time, including mid-run:
  - All outputs, counters, accumulator and delay line go to 0.
  - State goes to IDLE immediately.
  - No `out_valid`/`done` is produced for the aborted run.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `mac_sload`, `out_valid` = 0; `smp_addr`, `coef_addr`, `out_bin` = 0.
- Cycle 0 is the edge at which `start`=1 is sampled in IDLE.
- Pair (k,n) is issued in cycle 1+k·N+n.
- Memory data is valid in cycle 2+k·N+n; the MAC accumulates it at the end of that cycle.
- `out_valid` for bin k is asserted in cycle (k+1)·N+2, one cycle per bin.
  - It overlaps the term-0 data cycle of bin k+1.
  - Any gap between successive `out_valid` pulses is exactly N cycles.
- Last issue is in cycle NUM_BINS·N; `done` is in cycle NUM_BINS·N+2.
- `busy` is high in cycles 1..NUM_BINS·N+2 and low from cycle NUM_BINS·N+3.
- Latency from `start` to first result is N+2 cycles. Run length is NUM_BINS·N+2 cycles.
- MAC arithmetic is the MAC's own (product bits [23:8], accumulate wrap). This block adds no arithmetic.

## Test plan
- Reset: hold `aclr`=0, toggle `start` → all outputs 0, `busy` stays 0; release → IDLE.
- Address sequence, default params: pulse `start`.
  - k=3 issues `coef_addr` 0,3,6,…,30,1,4,… (mod 32).
  - `mac_sload` is high only at issue cycles 1, 33, 65, ….
- Result timing with MAC and memory models: all samples = 256, all coefficients = 256.
  - Each `out_valid` sees `adder_out` = 8192.
  - `out_bin` runs 0..31 at cycles 34, 66, …, 1026.
  - `done` at cycle 1026; `busy` low at 1027.
- NUM_BINS=1: `start` → single `out_valid` with `out_bin`=0 at cycle 34, coincident with `done`; 34 `busy` cycles.
- `start` held high throughout → second run's first issue in cycle 1028; `start` pulses mid-run are ignored.
- `aclr` low at cycle 500 → next cycle all outputs 0, no `done`; a fresh `start` reproduces the cycle-34 first result.
